st2_ctrl_pipe_reg: RTL
======================

// Module: st2_ctrl_pipe_reg
// PURPOSE
//  Parametrised ID->EX pipeline register with built-in hazard control. Registers the stage-2
//  control word and operand bundle; on flush or bubble request, substitutes a NOP control
//  word (BUBBLE_CTRL). Inserts multi-cycle bubble sequences via a down-counter FSM and
//  back-pressures IF/ID while the sequence runs. Sits between decode and execute.
// PARAMETERS
//  CTRL_W       16      control word width
//  DATA_W       32      width of one operand
//  NUM_OPS      3       operands carried (rs, rt, imm)
//  BUBBLE_MAX   3       maximum bubble cycles per request
//  CNT_W        2       counter width, = $clog2(BUBBLE_MAX+1)
//  BUBBLE_CTRL  16'h0   control value driven during a bubble or after a flush
// PORTS
//  clk            in   1               rising-edge clock
//  rst            in   1               synchronous, active-high reset
//  ctrl_in        in   CTRL_W          decoded control word
//  ops_in         in   NUM_OPS*DATA_W  operand bundle, op0 in LSBs
//  valid_in       in   1               ctrl_in/ops_in carry a real instruction
//  stall          in   1               freeze register and FSM (downstream stall)
//  flush          in   1               kill the instruction being captured; abort any bubble
//  bubble_req     in   1               request insertion of bubble_len bubbles
//  bubble_len     in   CNT_W           bubble cycles requested
//  ctrl_out       out  CTRL_W          registered control to EX
//  ops_out        out  NUM_OPS*DATA_W  registered operands to EX
//  valid_out      out  1               ctrl_out is a real instruction
//  hold_upstream  out  1               IF/ID must hold its current instruction
//  bubble_active  out  1               FSM in BUBBLE state
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): ctrl_out=BUBBLE_CTRL, ops_out=0, valid_out=0, FSM=IDLE,
//    cnt=0. hold_upstream=0 and bubble_active=0 follow from the reset state.
//  - Latency: 1 cycle, input to output, in normal flow.
//  - Priority at each edge: rst > flush > stall > bubble > normal capture.
//  - flush: ctrl_out<=BUBBLE_CTRL, ops_out<=0, valid_out<=0, FSM<=IDLE, cnt<=0.
//    Flush overrides stall. A bubble_req in the same cycle is discarded.
//  - stall (no flush): all registers, FSM and cnt hold. hold_upstream keeps its combinational value.
//  - FSM IDLE:
//      bubble_req=1 and bubble_len!=0:
//        eff_len = min(bubble_len, BUBBLE_MAX).
//        This edge: emit one bubble (ctrl_out<=BUBBLE_CTRL, ops_out<=0, valid_out<=0).
//        eff_len==1 -> stay IDLE.
//        eff_len>1 -> go to BUBBLE with cnt<=eff_len-1.
//      bubble_req=1 and bubble_len==0: treated as normal capture.
//      otherwise (normal capture): ctrl_out<=ctrl_in, ops_out<=ops_in, valid_out<=valid_in.
//        valid_in=0 -> ctrl_out<=BUBBLE_CTRL.
//  - FSM BUBBLE: each unstalled edge emits a bubble and decrements cnt.
//      cnt==1 -> return to IDLE, cnt<=0.
//      bubble_req is ignored in BUBBLE; no retrigger or extension.
//  - hold_upstream (combinational) = (FSM==BUBBLE) | (FSM==IDLE & bubble_req & bubble_len!=0 & !flush).
//    It guarantees the instruction present during the request is captured on the first
//    normal edge after the sequence. Result: exactly eff_len bubbles, then that instruction.
//  - bubble_active = (FSM==BUBBLE), registered state only.
//  - Widths: no arithmetic on data paths. cnt decrement never underflows (guarded by cnt==1 exit).
// STRUCTURE
//  - Package st2_pipe_pkg:
//      typedef enum {ST_IDLE, ST_BUBBLE} st2_state_t.
//      localparam NOP_CTRL = 16'h0, the default for BUBBLE_CTRL.
//  - Sub-module st2_bubble_counter:
//      contents: FSM + cnt, saturation and priority logic.
//      outputs: emit_bubble, hold_upstream, bubble_active.
//  - The top level holds only the data/control register bank and its muxing.
// TESTING
//  1. rst=1 for 2 cycles then release -> ctrl_out=16'h0, ops_out=0, valid_out=0, hold_upstream=0.
//  2. ctrl_in=16'hFC72, valid_in=1, no hazards -> ctrl_out=16'hFC72, valid_out=1 one edge later.
//     Flush on the next edge -> ctrl_out=16'h0, valid_out=0.
//  3. bubble_req=1, bubble_len=2, ctrl_in=16'hFC72 held -> hold_upstream=1 for 2 cycles.
//     Outputs: 2 bubbles (ctrl_out=0), then ctrl_out=16'hFC72, valid_out=1.
//  4. bubble_len=3 with stall=1 asserted in the 2nd bubble cycle for 2 cycles -> cnt frozen.
//     Output: 3 bubbles total, the sequence stretched by 2 cycles.
//  5. bubble_len=3 (BUBBLE_MAX=2 build) -> 2 bubbles only.
//     flush mid-sequence -> FSM=IDLE, hold_upstream=0 the same cycle.
//  6. flush and stall together -> flush wins.
//     rst during BUBBLE -> all outputs return to reset values on that edge.

Source files
------------

// File: rtl/st2_pipe_pkg.sv
// Shared types and constants for the ID->EX pipeline register and its bubble control.
package st2_pipe_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_BUBBLE = 1'b1
   } st2_state_t;

   localparam logic [15:0] NOP_CTRL = 16'h0;

endpackage

// File: rtl/st2_bubble_counter.sv
// Bubble-sequence FSM: saturates the requested length, counts bubbles down, and drives
// the upstream hold; stall freezes it, flush aborts it back to IDLE.
module st2_bubble_counter
   import st2_pipe_pkg::*;
#(
   parameter int BUBBLE_MAX = 3,
   parameter int CNT_W      = $clog2(BUBBLE_MAX + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             stall,
   input  logic             bubble_req,
   input  logic [CNT_W-1:0] bubble_len,
   output logic             emit_bubble,
   output logic             hold_upstream,
   output logic             bubble_active
);

   st2_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_bubble_active;
   logic             w_req_ok;
   logic [CNT_W-1:0] w_eff_len;

   always_comb begin
      w_req_ok  = bubble_req && (bubble_len != '0);
      w_eff_len = (bubble_len > CNT_W'(BUBBLE_MAX)) ? CNT_W'(BUBBLE_MAX) : bubble_len;
      hold_upstream = (r_state == ST_BUBBLE) ||
                      ((r_state == ST_IDLE) && w_req_ok && !flush);
      emit_bubble   = !flush && !stall &&
                      ((r_state == ST_BUBBLE) || ((r_state == ST_IDLE) && w_req_ok));
   end

   assign bubble_active = r_bubble_active;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_state         <= ST_IDLE;
         r_cnt           <= '0;
         r_bubble_active <= 1'b0;
      end else if (!stall) begin
         case (r_state)
            ST_IDLE: begin
               // The request edge itself emits the first bubble; only the rest need BUBBLE.
               if (w_req_ok && (w_eff_len > CNT_W'(1))) begin
                  r_state         <= ST_BUBBLE;
                  r_cnt           <= w_eff_len - CNT_W'(1);
                  r_bubble_active <= 1'b1;
               end
            end
            ST_BUBBLE: begin
               if (r_cnt == CNT_W'(1)) begin
                  r_state         <= ST_IDLE;
                  r_cnt           <= '0;
                  r_bubble_active <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state         <= ST_IDLE;
               r_cnt           <= '0;
               r_bubble_active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/st2_ctrl_pipe_reg.sv
// ID->EX register bank: 1-cycle capture of control+operands, NOP substitution on flush
// or bubble; hold_upstream back-pressures IF/ID while a bubble sequence runs.
module st2_ctrl_pipe_reg
   import st2_pipe_pkg::*;
#(
   parameter int                CTRL_W      = 16,
   parameter int                DATA_W      = 32,
   parameter int                NUM_OPS     = 3,
   parameter int                BUBBLE_MAX  = 3,
   parameter int                CNT_W       = $clog2(BUBBLE_MAX + 1),
   parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(NOP_CTRL)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CTRL_W-1:0]         ctrl_in,
   input  logic [NUM_OPS*DATA_W-1:0] ops_in,
   input  logic                      valid_in,
   input  logic                      stall,
   input  logic                      flush,
   input  logic                      bubble_req,
   input  logic [CNT_W-1:0]          bubble_len,
   output logic [CTRL_W-1:0]         ctrl_out,
   output logic [NUM_OPS*DATA_W-1:0] ops_out,
   output logic                      valid_out,
   output logic                      hold_upstream,
   output logic                      bubble_active
);

   logic                      w_emit_bubble;
   logic [CTRL_W-1:0]         r_ctrl;
   logic [NUM_OPS*DATA_W-1:0] r_ops;
   logic                      r_valid;

   st2_bubble_counter #(
      .BUBBLE_MAX (BUBBLE_MAX),
      .CNT_W      (CNT_W)
   ) u_bubble_counter (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .stall         (stall),
      .bubble_req    (bubble_req),
      .bubble_len    (bubble_len),
      .emit_bubble   (w_emit_bubble),
      .hold_upstream (hold_upstream),
      .bubble_active (bubble_active)
   );

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_ctrl  <= BUBBLE_CTRL;
         r_ops   <= '0;
         r_valid <= 1'b0;
      end else if (stall) begin
         r_ctrl  <= r_ctrl;
         r_ops   <= r_ops;
         r_valid <= r_valid;
      end else if (w_emit_bubble) begin
         r_ctrl  <= BUBBLE_CTRL;
         r_ops   <= '0;
         r_valid <= 1'b0;
      end else begin
         // Operands pass through even when invalid; only the control word is scrubbed.
         r_ctrl  <= valid_in ? ctrl_in : BUBBLE_CTRL;
         r_ops   <= ops_in;
         r_valid <= valid_in;
      end
   end

   assign ctrl_out  = r_ctrl;
   assign ops_out   = r_ops;
   assign valid_out = r_valid;

endmodule
